// File: rtl/axis_ad5791_ramp_if.sv
// axis_ad5791_ramp_if: AXI-Stream bundle (tdata/tvalid/tready) of parameterised width W
//   master: drives tdata/tvalid, samples tready
//   slave : samples tdata/tvalid, drives tready
interface axis_ad5791_ramp_if #(parameter int W = 24);
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;
  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_ad5791_ramp.sv
// axis_ad5791_ramp: AD5791 init sequencer and slew-limited DAC frame generator
//   s_axis_aclk    in  clock
//   s_axis_aresetn in  async active-low reset
//   s_axis         slave  target DAC codes (offset binary, S_DATA_WIDTH bits)
//   m_axis         master 24-bit AD5791 frames {R/W=0, addr[2:0], data[19:0]}
//   dac_code       out last code handshaken into the DAC register
//   settled        out init done, idle, and current == target
module axis_ad5791_ramp #(
  parameter int          S_DATA_WIDTH = 20,
  parameter logic [19:0] MAX_STEP     = 20'h01000,
  parameter logic [19:0] CTRL_INIT    = 20'h00012,
  parameter logic [19:0] RESET_CODE   = 20'h80000
) (
  input  logic               s_axis_aclk,
  input  logic               s_axis_aresetn,
  axis_ad5791_ramp_if.slave  s_axis,
  axis_ad5791_ramp_if.master m_axis,
  output logic [19:0]        dac_code,
  output logic               settled
);
  typedef enum logic [1:0] {INIT_CTRL, INIT_DAC, IDLE, EMIT} state_t;
  state_t      r_state;
  logic [19:0] r_cur, r_tgt;
  logic [23:0] r_tdata;
  logic        r_tvalid, r_tready, r_settled;
  logic [19:0] w_in, w_tgt_nx, w_next;
  logic [20:0] w_diff, w_abs;
  logic        w_acc;
  // narrow inputs are MSB-justified; wide inputs keep their low 20 bits
  if (S_DATA_WIDTH >= 20) begin : g_wide
    assign w_in = s_axis.tdata[19:0];
  end else begin : g_narrow
    assign w_in = {s_axis.tdata, {(20-S_DATA_WIDTH){1'b0}}};
  end
  assign w_acc    = s_axis.tvalid & r_tready;
  assign w_tgt_nx = w_acc ? w_in : r_tgt;
  // 21-bit signed difference; a full step is only taken when |diff| exceeds it, so no wrap
  assign w_diff = {1'b0, r_tgt} - {1'b0, r_cur};
  assign w_abs  = w_diff[20] ? -w_diff : w_diff;
  assign w_next = (MAX_STEP == '0 || w_abs <= {1'b0, MAX_STEP}) ? r_tgt :
                  w_diff[20] ? r_cur - MAX_STEP : r_cur + MAX_STEP;
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      r_state   <= INIT_CTRL;
      r_cur     <= RESET_CODE;
      r_tgt     <= RESET_CODE;
      r_tdata   <= '0;
      r_tvalid  <= 1'b0;
      r_tready  <= 1'b0;
      r_settled <= 1'b0;
    end else begin
      if (w_acc) r_tgt <= w_in;
      case (r_state)
        INIT_CTRL:
          if (!r_tvalid) begin
            r_tdata  <= {4'b0010, CTRL_INIT};
            r_tvalid <= 1'b1;
          end else if (m_axis.tready) begin
            r_tdata <= {4'b0001, RESET_CODE};
            r_state <= INIT_DAC;
          end
        INIT_DAC:
          if (m_axis.tready) begin
            r_tvalid  <= 1'b0;
            r_cur     <= r_tdata[19:0];
            r_tready  <= 1'b1;
            r_settled <= w_tgt_nx == r_tdata[19:0];
            r_state   <= IDLE;
          end
        IDLE:
          if (r_tgt != r_cur) begin
            r_tdata   <= {4'b0001, w_next};
            r_tvalid  <= 1'b1;
            r_settled <= 1'b0;
            r_state   <= EMIT;
          end else r_settled <= w_tgt_nx == r_cur;
        EMIT:
          if (m_axis.tready) begin
            r_tvalid  <= 1'b0;
            r_cur     <= r_tdata[19:0];
            r_settled <= w_tgt_nx == r_tdata[19:0];
            r_state   <= IDLE;
          end
        default: r_state <= INIT_CTRL;
      endcase
    end
  end
  assign m_axis.tdata  = r_tdata;
  assign m_axis.tvalid = r_tvalid;
  assign s_axis.tready = r_tready;
  assign dac_code      = r_cur;
  assign settled       = r_settled;
endmodule

// File: tb/tb_axis_ad5791_ramp.sv
// tb_axis_ad5791_ramp: scoreboard bench for a slew-limited and an unlimited ramp instance
module tb_axis_ad5791_ramp;
  localparam logic [19:0] STEP = 20'h01000;
  logic clk, rst_n;
  logic [19:0] dac, dac0;
  logic settled, settled0;
  int errs = 0, checks = 0;
  int mcur = 'h80000, mcur0 = 'h80000;
  logic [23:0] exp_q[$], exp0_q[$];
  axis_ad5791_ramp_if #(.W(20)) s_if();
  axis_ad5791_ramp_if #(.W(24)) m_if();
  axis_ad5791_ramp_if #(.W(20)) s0_if();
  axis_ad5791_ramp_if #(.W(24)) m0_if();
  axis_ad5791_ramp #(.MAX_STEP(STEP)) u_dut (
    .s_axis_aclk(clk), .s_axis_aresetn(rst_n), .s_axis(s_if), .m_axis(m_if),
    .dac_code(dac), .settled(settled));
  axis_ad5791_ramp #(.MAX_STEP(20'h0)) u_dut0 (
    .s_axis_aclk(clk), .s_axis_aresetn(rst_n), .s_axis(s0_if), .m_axis(m0_if),
    .dac_code(dac0), .settled(settled0));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [23:0] a, input logic [23:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  // reference: walk from one code to another in plain integer steps of at most s
  function automatic void ramp(input bit z, input int from, input int to);
    int c = from;
    int s = z ? 0 : int'(STEP);
    while (c != to) begin
      if (s == 0 || (to > c ? to - c : c - to) <= s) c = to;
      else c = to > c ? c + s : c - s;
      if (z) exp0_q.push_back({4'h1, c[19:0]});
      else exp_q.push_back({4'h1, c[19:0]});
    end
  endfunction
  function automatic void push_init();
    exp_q.push_back(24'h200012);
    exp_q.push_back(24'h180000);
    exp0_q.push_back(24'h200012);
    exp0_q.push_back(24'h180000);
  endfunction
  always @(negedge clk)
    if (rst_n && m_if.tvalid && m_if.tready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL frame: unexpected %h", m_if.tdata);
      end else chk("frame", m_if.tdata, exp_q.pop_front());
    end
  always @(negedge clk)
    if (rst_n && m0_if.tvalid && m0_if.tready) begin
      if (exp0_q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL frame0: unexpected %h", m0_if.tdata);
      end else chk("frame0", m0_if.tdata, exp0_q.pop_front());
    end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input bit z, input logic [19:0] c);
    int n = 0;
    if (z) begin s0_if.tdata = c; s0_if.tvalid = 1'b1; end
    else begin s_if.tdata = c; s_if.tvalid = 1'b1; end
    do begin @(negedge clk); n++; end while (!(z ? s0_if.tready : s_if.tready) && n < 100);
    chk(z ? "accept0" : "accept", {23'd0, z ? s0_if.tready : s_if.tready}, 24'd1);
    tick();
    s_if.tvalid = 1'b0;
    s0_if.tvalid = 1'b0;
    if (z) begin ramp(1'b1, mcur0, int'(c)); mcur0 = int'(c); end
    else begin ramp(1'b0, mcur, int'(c)); mcur = int'(c); end
  endtask
  task automatic wait_settled(input bit z);
    int n = 0;
    while (n < 3000 && !(z ? (settled0 && exp0_q.size() == 0) : (settled && exp_q.size() == 0))) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 3000) begin
      errs++;
      $display("FAIL settle%0d: timeout, %0d frames outstanding", z, z ? exp0_q.size() : exp_q.size());
    end
    tick();
  endtask
  task automatic wait_tvalid();
    int n = 0;
    while (n < 100 && !m_if.tvalid) begin
      @(negedge clk);
      n++;
    end
    chk("tvalid_wait", {23'd0, m_if.tvalid}, 24'd1);
  endtask
  initial begin
    s_if.tdata = '0; s_if.tvalid = 1'b0; m_if.tready = 1'b1;
    s0_if.tdata = '0; s0_if.tvalid = 1'b0; m0_if.tready = 1'b1;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_tvalid", {23'd0, m_if.tvalid}, 24'd0);
    chk("rst_tdata", m_if.tdata, 24'h0);
    chk("rst_sready", {23'd0, s_if.tready}, 24'd0);
    chk("rst_settled", {23'd0, settled}, 24'd0);
    chk("rst_dac", {4'd0, dac}, 24'h080000);
    push_init();
    repeat (3) tick();
    rst_n = 1'b1;
    wait_settled(1'b0);
    wait_settled(1'b1);
    chk("init_sready", {23'd0, s_if.tready}, 24'd1);
    chk("init_settled", {23'd0, settled}, 24'd1);
    chk("init_dac", {4'd0, dac}, 24'h080000);
    send(1'b0, 20'h82800);
    wait_settled(1'b0);
    chk("t2_dac", {4'd0, dac}, 24'h082800);
    chk("t2_settled", {23'd0, settled}, 24'd1);
    send(1'b1, 20'h82800);
    wait_settled(1'b1);
    send(1'b1, 20'h00000);
    wait_settled(1'b1);
    chk("t3_dac0", {4'd0, dac0}, 24'h000000);
    send(1'b1, 20'hFFFFF);
    wait_settled(1'b1);
    chk("t3_dac0_max", {4'd0, dac0}, 24'h0FFFFF);
    send(1'b0, 20'h00000);
    wait_settled(1'b0);
    chk("zero_dac", {4'd0, dac}, 24'h000000);
    send(1'b0, 20'hFFFFF);
    wait_settled(1'b0);
    chk("max_dac", {4'd0, dac}, 24'h0FFFFF);
    for (int i = 0; i < 8; i++) begin
      logic [19:0] r, r0;
      r = 20'($urandom_range(0, 20'hFFFFF));
      r0 = 20'($urandom_range(0, 20'hFFFFF));
      send(1'b0, r);
      send(1'b1, r0);
      wait_settled(1'b0);
      wait_settled(1'b1);
      chk("rand_dac", {4'd0, dac}, {4'd0, r});
      chk("rand_dac0", {4'd0, dac0}, {4'd0, r0});
    end
    send(1'b0, 20'h80000);
    wait_settled(1'b0);
    m_if.tready = 1'b0;
    send(1'b0, 20'h84000);
    wait_tvalid();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_tvalid", {23'd0, m_if.tvalid}, 24'd1);
      chk("hold_tdata", m_if.tdata, 24'h181000);
    end
    tick();
    m_if.tready = 1'b1;
    wait_settled(1'b0);
    chk("t4_dac", {4'd0, dac}, 24'h084000);
    send(1'b0, 20'h80000);
    wait_settled(1'b0);
    m_if.tready = 1'b0;
    send(1'b0, 20'h84000);
    wait_tvalid();
    chk("t5_inflight", m_if.tdata, 24'h181000);
    tick();
    exp_q.delete();
    exp_q.push_back(24'h181000);
    mcur = 'h81000;
    send(1'b0, 20'h7F800);
    m_if.tready = 1'b1;
    wait_settled(1'b0);
    chk("t5_dac", {4'd0, dac}, 24'h07F800);
    m_if.tready = 1'b0;
    send(1'b0, 20'h84000);
    wait_tvalid();
    tick();
    rst_n = 1'b0;
    #1;
    chk("t6_tvalid", {23'd0, m_if.tvalid}, 24'd0);
    chk("t6_tdata", m_if.tdata, 24'h0);
    chk("t6_sready", {23'd0, s_if.tready}, 24'd0);
    chk("t6_dac", {4'd0, dac}, 24'h080000);
    exp_q.delete();
    exp0_q.delete();
    push_init();
    mcur = 'h80000;
    mcur0 = 'h80000;
    m_if.tready = 1'b1;
    tick();
    rst_n = 1'b1;
    wait_settled(1'b0);
    wait_settled(1'b1);
    chk("t6_settled", {23'd0, settled}, 24'd1);
    chk("t6_dac_after", {4'd0, dac}, 24'h080000);
    repeat (5) tick();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
